// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: fills the shared S-memory with the identity
// permutation, then runs the KSA swap loop and pulses fin_strobe when done.
module ksa_engine #(
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [7:0]             data_from_s_mem,
    output logic                   wr_en,
    output logic [7:0]             addr_to_s_mem,
    output logic [7:0]             data_to_s_mem,
    output logic                   task_on,
    output logic                   fin_strobe
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_RD_I,
        S_LAT_I,
        S_RD_J,
        S_LAT_J,
        S_WR_I,
        S_WR_J,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [7:0]    s_i_q, s_i_d;
    logic [7:0]    s_j_q, s_j_d;
    logic [7:0]    key_byte;

    // Key byte selected by the key index; byte 0 is the most-significant byte.
    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KW'(b)) begin
                key_byte = key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            s_i_q   <= '0;
            s_j_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            s_i_q   <= s_i_d;
            s_j_q   <= s_j_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        s_i_d   = s_i_q;
        s_j_d   = s_j_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    i_d     = '0;
                end
            end
            S_INIT: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    state_d = S_RD_I;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            S_RD_I: state_d = S_LAT_I;
            S_LAT_I: begin
                s_i_d   = data_from_s_mem;
                j_d     = j_q + data_from_s_mem + key_byte;
                state_d = S_RD_J;
            end
            S_RD_J: state_d = S_LAT_J;
            S_LAT_J: begin
                s_j_d   = data_from_s_mem;
                state_d = S_WR_I;
            end
            S_WR_I: state_d = S_WR_J;
            S_WR_J: begin
                i_d    = i_q + 8'd1;
                kidx_d = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
                state_d = (i_q == 8'hFF) ? S_DONE : S_RD_I;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-port and status outputs decoded from registered state only.
    always_comb begin
        wr_en         = 1'b0;
        addr_to_s_mem = '0;
        data_to_s_mem = '0;
        task_on       = (state_q != S_IDLE);
        fin_strobe    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                addr_to_s_mem = i_q;
                data_to_s_mem = i_q;
                wr_en         = 1'b1;
            end
            S_RD_I, S_LAT_I: addr_to_s_mem = i_q;
            S_RD_J, S_LAT_J: addr_to_s_mem = j_q;
            S_WR_I: begin
                addr_to_s_mem = i_q;
                data_to_s_mem = s_j_q;
                wr_en         = 1'b1;
            end
            S_WR_J: begin
                addr_to_s_mem = j_q;
                data_to_s_mem = s_i_q;
                wr_en         = 1'b1;
            end
            S_DONE: fin_strobe = 1'b1;
            default: ;
        endcase
    end

endmodule
